multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 23 ++
 rtl/multicycle_ctrl_if.sv | 31 +++
 rtl/alu_op_dec.sv | 15 +
 rtl/multicycle_ctrl.sv | 79 +++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encodings, opcode and ALU op constants shared by the multicycle controller.
package ctrl_pkg;
    localparam logic [2:0] ST_INTR   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;
    localparam logic [6:0] OPC_R   = 7'h33;
    localparam logic [6:0] OPC_I   = 7'h13;
    localparam logic [6:0] OPC_LW  = 7'h03;
    localparam logic [6:0] OPC_SW  = 7'h23;
    localparam logic [6:0] OPC_BEQ = 7'h63;
    localparam logic [6:0] OPC_JAL = 7'h6F;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b110;
    function automatic logic isLegal(input logic [6:0] opc);
        return opc inside {OPC_R, OPC_I, OPC_LW, OPC_SW, OPC_BEQ, OPC_JAL};
    endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/handshake inputs and datapath control outputs of the controller.
interface multicycle_ctrl_if;
    logic [31:0] ins;
    logic        zero;
    logic        mem_ready;
    logic        int_req;
    logic        ir_we;
    logic        pc_we;
    logic        INT;
    logic        RegWrite;
    logic        ALUSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        Mem2Reg;
    logic        isbranch;
    logic        isjump;
    logic [2:0]  op;
    logic        busy;
    logic        illegal;
    logic [15:0] retire_cnt;
    modport master (
        output ins, zero, mem_ready, int_req,
        input  ir_we, pc_we, INT, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg,
               isbranch, isjump, op, busy, illegal, retire_cnt
    );
    modport slave (
        input  ins, zero, mem_ready, int_req,
        output ir_we, pc_we, INT, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg,
               isbranch, isjump, op, busy, illegal, retire_cnt
    );
endinterface

// File: rtl/alu_op_dec.sv
// alu_op_dec: maps the latched opcode, funct3 and funct7[5] to the ALU operation.
module alu_op_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] op
);
    assign op = opcode == OPC_BEQ ? ALU_SUB :
                opcode != OPC_R   ? ALU_ADD :
                funct3 == 3'b110  ? ALU_OR  :
                funct3 == 3'b111  ? ALU_AND :
                (funct3 == 3'b000 && funct7b5) ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle instruction sequencer with interrupt entry, illegal-opcode halt
// and a retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    multicycle_ctrl_if.slave bus
);
    logic [2:0]  state;
    logic [2:0]  nextState;
    logic [2:0]  afterRetire;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [2:0]  decOp;
    logic [15:0] retireCnt;
    logic        isR, isLw, isSw, isBeq, isJal;
    logic        aluPhase, pcWe, retire;
    logic        unusedBits;

    alu_op_dec uDec (.opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .op(decOp));

    assign isR   = opcode == OPC_R;
    assign isLw  = opcode == OPC_LW;
    assign isSw  = opcode == OPC_SW;
    assign isBeq = opcode == OPC_BEQ;
    assign isJal = opcode == OPC_JAL;
    assign aluPhase = state == ST_EXEC || state == ST_MEM || state == ST_WB;
    // sw retires in the MEM cycle that completes; every other pc_we outside INTR is a retire
    assign pcWe = state == ST_INTR || state == ST_WB || (state == ST_EXEC && (isBeq || isJal))
                  || (state == ST_MEM && isSw && bus.mem_ready);
    assign retire = pcWe && state != ST_INTR;
    assign afterRetire = bus.int_req ? ST_INTR : ST_FETCH;

    always_comb begin
        nextState = state == ST_INTR   ? ST_FETCH :
                    state == ST_FETCH  ? ST_DECODE :
                    state == ST_DECODE ? (isLegal(opcode) ? ST_EXEC : ST_HALT) :
                    state == ST_EXEC   ? ((isBeq || isJal) ? afterRetire : (isLw || isSw) ? ST_MEM : ST_WB) :
                    state == ST_MEM    ? (!bus.mem_ready ? ST_MEM : isLw ? ST_WB : afterRetire) :
                    state == ST_WB     ? afterRetire : ST_HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INTR;
            opcode    <= '0;
            funct3    <= '0;
            funct7b5  <= 1'b0;
            retireCnt <= '0;
        end else begin
            state <= nextState;
            if (state == ST_FETCH) begin
                opcode   <= bus.ins[6:0];
                funct3   <= bus.ins[14:12];
                funct7b5 <= bus.ins[30];
            end
            if (retire) retireCnt <= retireCnt + 16'd1;
        end
    end

    assign bus.ir_we      = state == ST_FETCH;
    assign bus.pc_we      = pcWe;
    assign bus.INT        = state == ST_INTR;
    assign bus.RegWrite   = state == ST_WB || (state == ST_EXEC && isJal);
    assign bus.ALUSrc     = aluPhase && !(isR || isBeq);
    assign bus.op         = aluPhase ? decOp : 3'b000;
    assign bus.MemRead    = state == ST_MEM && isLw;
    assign bus.MemWrite   = state == ST_MEM && isSw;
    assign bus.Mem2Reg    = state == ST_WB && isLw;
    assign bus.isbranch   = state == ST_EXEC && isBeq;
    assign bus.isjump     = state == ST_EXEC && isJal;
    assign bus.busy       = state != ST_HALT;
    assign bus.illegal    = state == ST_HALT;
    assign bus.retire_cnt = retireCnt;
    // branch resolution and register fields are consumed by the datapath, not here
    assign unusedBits = ^{bus.zero, bus.ins[31], bus.ins[29:15], bus.ins[11:7]};
endmodule
